// File: rtl/t_toggle_pulse_gen_pkg.sv
// Shared definitions for the push-button toggle pulse generator.
//   - FSM state encoding (2-bit, kept as plain localparams so legacy
//     code comparing raw state values keeps working)
//   - elaboration-time helpers used to size the counters
package t_toggle_pulse_gen_pkg;

    localparam logic [1:0] ST_IDLE        = 2'd0;
    localparam logic [1:0] ST_PRESS_CHK   = 2'd1;
    localparam logic [1:0] ST_HELD        = 2'd2;
    localparam logic [1:0] ST_RELEASE_CHK = 2'd3;

    // Number of bits needed to hold values 0 .. value-1.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/t_toggle_pulse_gen_sync.sv
// bit_sync: multi-flop synchroniser for one asynchronous level.
// Ports:
//   clk    in  1  sampling clock
//   reset  in  1  asynchronous active-low reset, clears the chain to 0
//   d      in  1  asynchronous input level
//   q      out 1  d delayed by STAGES clock edges
module bit_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d};
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/t_toggle_pulse_gen.sv
// t_toggle_pulse_gen: turns a raw, bouncy push-button into clean
// single-cycle toggle requests, with optional auto-repeat while held.
// Ports:
//   clk     in  1  system clock, rising edge
//   reset   in  1  asynchronous active-low reset
//   btn     in  1  raw button level (asynchronous, may bounce)
//   T       out 1  one-cycle toggle request per accepted press / repeat
//   btn_db  out 1  debounced button level
//   busy    out 1  high whenever the FSM is outside IDLE
//
// state          | meaning
// ST_IDLE        | button released and stable
// ST_PRESS_CHK   | synced level went high, counting stable-high samples
// ST_HELD        | press accepted; repeat timer running
// ST_RELEASE_CHK | synced level went low, counting stable-low samples
module t_toggle_pulse_gen
    import t_toggle_pulse_gen_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int REPEAT_EN       = 0,
    parameter int REPEAT_CYCLES   = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic T,
    output logic btn_db,
    output logic busy
);

    localparam int CNT_W = clog2(max2(DEBOUNCE_CYCLES, REPEAT_CYCLES) + 1);
    localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] RPT_LAST = CNT_W'(REPEAT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             btn_s;
    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] rpt_q, rpt_d;
    logic             t_q, t_d;
    logic             db_q, db_d;
    logic             busy_q, busy_d;

    bit_sync #(
        .STAGES (SYNC_STAGES)
    ) u_btn_sync (
        .clk   (clk),
        .reset (reset),
        .d     (btn),
        .q     (btn_s)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rpt_d   = rpt_q;
        t_d     = 1'b0;
        db_d    = db_q;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (btn_s) begin
                    state_d = ST_PRESS_CHK;
                    cnt_d   = CNT_ONE;
                end
            end
            ST_PRESS_CHK: begin
                if (!btn_s) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == DB_LAST) begin
                    state_d = ST_HELD;
                    cnt_d   = '0;
                    rpt_d   = '0;
                    t_d     = 1'b1;
                    db_d    = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_HELD: begin
                if (!btn_s) begin
                    state_d = ST_RELEASE_CHK;
                    cnt_d   = CNT_ONE;
                end else if (rpt_q == RPT_LAST) begin
                    // Without auto-repeat the timer simply parks at its
                    // terminal value instead of wrapping.
                    if (REPEAT_EN != 0) begin
                        t_d   = 1'b1;
                        rpt_d = '0;
                    end
                end else begin
                    rpt_d = rpt_q + CNT_ONE;
                end
            end
            ST_RELEASE_CHK: begin
                if (btn_s) begin
                    // Release bounce: back to HELD with a fresh repeat period.
                    state_d = ST_HELD;
                    cnt_d   = '0;
                    rpt_d   = '0;
                end else if (cnt_q == DB_LAST) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    db_d    = 1'b0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                rpt_d   = '0;
                db_d    = 1'b0;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            rpt_q   <= '0;
            t_q     <= 1'b0;
            db_q    <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rpt_q   <= rpt_d;
            t_q     <= t_d;
            db_q    <= db_d;
            busy_q  <= busy_d;
        end
    end

    assign T      = t_q;
    assign btn_db = db_q;
    assign busy   = busy_q;

endmodule

// File: tb/tb_t_toggle_pulse_gen.sv
module tb_t_toggle_pulse_gen;

    localparam int S = 2;
    localparam int D = 4;
    localparam int R = 8;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic btn   = 1'b0;
    logic t0, db0, busy0;
    logic t1, db1, busy1;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    // Instance 0: defaults (one T per press). Instance 1: auto-repeat.
    t_toggle_pulse_gen #(
        .SYNC_STAGES(S), .DEBOUNCE_CYCLES(D), .REPEAT_EN(0), .REPEAT_CYCLES(R)
    ) dut0 (
        .clk(clk), .reset(reset), .btn(btn), .T(t0), .btn_db(db0), .busy(busy0)
    );

    t_toggle_pulse_gen #(
        .SYNC_STAGES(S), .DEBOUNCE_CYCLES(D), .REPEAT_EN(1), .REPEAT_CYCLES(R)
    ) dut1 (
        .clk(clk), .reset(reset), .btn(btn), .T(t1), .btn_db(db1), .busy(busy1)
    );

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: run-length view of the synced button.
    // A level change is accepted after D+1 consecutive samples of the new
    // level; while accepted-high, every R-th consecutive high sample
    // (counted from acceptance or from a bounced release) repeats T.
    logic [S-1:0] m_syn;
    logic         m_fin;
    int           m_run [2];
    int           m_hr  [2];
    logic         m_db  [2];
    logic         m_t   [2];

    task automatic model_step(input int i, input logic fin);
        m_t[i] = 1'b0;
        if (fin != m_db[i]) begin
            m_run[i]++;
            if (m_run[i] == D + 1) begin
                m_db[i]  = fin;
                m_run[i] = 0;
                if (fin) begin
                    m_t[i]  = 1'b1;
                    m_hr[i] = 0;
                end
            end
        end else begin
            if (m_db[i]) begin
                if (m_run[i] > 0) begin
                    m_hr[i] = 0;
                end else begin
                    m_hr[i]++;
                    if (i == 1 && m_hr[i] == R) begin
                        m_t[i]  = 1'b1;
                        m_hr[i] = 0;
                    end
                end
            end
            m_run[i] = 0;
        end
    endtask

    initial begin
        m_syn = '0;
        for (int i = 0; i < 2; i++) begin
            m_run[i] = 0; m_hr[i] = 0; m_db[i] = 1'b0; m_t[i] = 1'b0;
        end
    end

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_syn = '0;
            for (int i = 0; i < 2; i++) begin
                m_run[i] = 0; m_hr[i] = 0; m_db[i] = 1'b0; m_t[i] = 1'b0;
            end
        end else begin
            m_fin = m_syn[S-1];
            m_syn = {m_syn[S-2:0], btn};
            model_step(0, m_fin);
            model_step(1, m_fin);
        end
    end

    // Per-cycle compare against the model, plus the no-back-to-back-T rule.
    logic prev_t0 = 1'b0;
    logic prev_t1 = 1'b0;
    always @(negedge clk) begin
        check("T0",     int'(t0),    int'(m_t[0]));
        check("btn_db0", int'(db0),  int'(m_db[0]));
        check("busy0",  int'(busy0), int'(m_db[0] || (m_run[0] != 0)));
        check("T1",     int'(t1),    int'(m_t[1]));
        check("btn_db1", int'(db1),  int'(m_db[1]));
        check("busy1",  int'(busy1), int'(m_db[1] || (m_run[1] != 0)));
        check("T0_gap", int'(t0 && prev_t0), 0);
        check("T1_gap", int'(t1 && prev_t1), 0);
        prev_t0 <= t0;
        prev_t1 <= t1;
    end

    // Downstream toggle flip-flop driven by instance 0.
    logic q_tog   = 1'b0;
    int   t_total = 0;
    always @(posedge clk) begin
        if (t0) begin
            q_tog   <= ~q_tog;
            t_total <= t_total + 1;
        end
    end

    logic [63:0] rec_t0, rec_t1, rec_db0, rec_busy0;
    logic [63:0] ones = '1;
    logic [63:0] pat;

    // Called at a negedge. Cycle c: btn driven before edge c, outputs
    // recorded at the negedge after edge c.
    task automatic run_seq(input logic [63:0] p, input int len, input int n);
        rec_t0 = '0; rec_t1 = '0; rec_db0 = '0; rec_busy0 = '0;
        for (int c = 0; c < n; c++) begin
            btn = (c < len) ? p[c] : 1'b0;
            @(posedge clk);
            @(negedge clk);
            rec_t0[c]    = t0;
            rec_t1[c]    = t1;
            rec_db0[c]   = db0;
            rec_busy0[c] = busy0;
        end
    endtask

    function automatic int first_one(input logic [63:0] v);
        for (int c = 0; c < 64; c++) if (v[c]) return c;
        return -1;
    endfunction

    initial begin
        // 1. reset held with btn high, then released
        #1 reset = 1'b0;
        btn = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check("rst_T",    int'(t0),    0);
            check("rst_db",   int'(db0),   0);
            check("rst_busy", int'(busy0), 0);
        end
        reset = 1'b1;
        run_seq(ones, 10, 20);
        check("t1_first_T",  first_one(rec_t0), 6);
        check("t1_count_T0", $countones(rec_t0), 1);
        check("t1_count_T1", $countones(rec_t1), 1);
        check("t1_db_15",    int'(rec_db0[15]), 1);
        check("t1_db_16",    int'(rec_db0[16]), 0);
        check("t1_busy_end", int'(rec_busy0[19]), 0);

        // 2. clean press, 20 cycles
        run_seq(ones, 20, 32);
        check("t2_first_T",  first_one(rec_t0), 6);
        check("t2_count_T0", $countones(rec_t0), 1);
        check("t2_count_T1", $countones(rec_t1), 2);
        check("t2_db_5",     int'(rec_db0[5]), 0);
        check("t2_db_6",     int'(rec_db0[6]), 1);
        check("t2_db_25",    int'(rec_db0[25]), 1);
        check("t2_db_26",    int'(rec_db0[26]), 0);
        check("t2_busy_end", int'(rec_busy0[31]), 0);

        // 3. bounce 1,1,0,1,1,1,0
        pat = 64'b0111011;
        run_seq(pat, 7, 16);
        check("t3_count_T0", $countones(rec_t0), 0);
        check("t3_count_T1", $countones(rec_t1), 0);
        check("t3_db_ones",  $countones(rec_db0), 0);
        check("t3_busy_3",   int'(rec_busy0[3]), 1);
        check("t3_busy_4",   int'(rec_busy0[4]), 0);
        check("t3_busy_7",   int'(rec_busy0[7]), 1);
        check("t3_busy_8",   int'(rec_busy0[8]), 0);

        // 4. auto-repeat, 28 cycles held
        run_seq(ones, 28, 40);
        check("t4_T1_6",     int'(rec_t1[6]), 1);
        check("t4_T1_14",    int'(rec_t1[14]), 1);
        check("t4_T1_22",    int'(rec_t1[22]), 1);
        check("t4_count_T1", $countones(rec_t1), 3);
        check("t4_count_T0", $countones(rec_t0), 1);

        // 5. release bounce: held, low for 2 cycles, high again
        pat = '0;
        for (int c = 0; c < 20; c++) pat[c] = !(c == 12 || c == 13);
        run_seq(pat, 20, 36);
        check("t5_count_T0", $countones(rec_t0), 1);
        check("t5_count_T1", $countones(rec_t1), 1);
        check("t5_db_16",    int'(rec_db0[16]), 1);
        check("t5_db_ones",  $countones(rec_db0), 20);
        check("t5_db_26",    int'(rec_db0[26]), 0);

        // 6. reset asserted mid-HELD with the button still down
        run_seq(ones, 10, 10);
        check("t6_pre_db", int'(db0), 1);
        #2 reset = 1'b0;
        #1;
        check("t6_async_db0", int'(db0),   0);
        check("t6_async_db1", int'(db1),   0);
        check("t6_async_busy", int'(busy0), 0);
        check("t6_async_T",   int'(t0),    0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        run_seq(ones, 12, 22);
        check("t6_first_T",  first_one(rec_t0), 6);
        check("t6_count_T0", $countones(rec_t0), 1);
        check("t6_count_T1", $countones(rec_t1), 1);

        @(negedge clk);
        check("tog_pulses", t_total, 6);
        check("tog_q",      int'(q_tog), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
